ffe_cmp_slice: RTL and testbench
================================

// Module: ffe_cmp_slice
// PURPOSE
// Parallel receiver equaliser + slicer: numChannels ADC codes per clock feed a feed-forward
// equaliser (FFE) whose filtered outputs are sliced against per-channel thresholds into bits
// plus a confidence magnitude. Sits between the ADC code deserialiser and the bit-level
// back end (checker/recorder); all channels advance together, one word per clock.
// PARAMETERS
// numChannels        16  channels (samples) per clock word; index 0 = earliest in time
// maxWeightLength    10  FFE taps per channel; must satisfy maxWeightLength <= numChannels+1
// codeBitwidth        8  signed input code width
// weightBitwidth     10  signed tap weight width
// resultBitwidth      8  signed FFE output width (= slicer input width)
// shiftBitwidth       5  unsigned output-shift control width
// thresholdBitwidth   8  signed slicer threshold width
// confidenceBitwidth  8  unsigned confidence width
// PORTS
// clk              in   1                                    rising-edge clock
// rstb             in   1                                    asynchronous active-low reset
// new_shift_index  in   shiftBitwidth                        FFE right-shift amount
// new_weights      in   [numChannels][maxWeightLength] x weightBitwidth  signed taps, [ch][tap]
// codes            in   [numChannels] x codeBitwidth          signed input word
// new_thresh       in   [numChannels] x thresholdBitwidth     signed slicer thresholds
// results          out  [numChannels] x resultBitwidth        signed FFE outputs (registered)
// bit_out          out  [numChannels] x 1                     sliced bits (registered)
// confidence       out  [numChannels] x confidenceBitwidth    |result - thresh|, saturated
// BEHAVIOUR
// - rstb low (async): history, weight/shift/thresh registers, results, bit_out, confidence -> 0.
//   Deassertion is sampled on the next clk edge; no X ever leaves the block after reset.
// - Edge E0: codes registered into cur word, previous cur moves to prev word; new_weights,
//   new_shift_index, new_thresh registered (control updates take effect one edge after change).
// - Sample order: x[n], n = cycle*numChannels + i. Channel i of cur = x[n]; taps reaching
//   before index 0 read prev word (prev[numChannels+i-k]).
// - FFE: acc_i = sum_{k=0..L-1} w[i][k] * x[n-k], full precision
//   (codeBitwidth+weightBitwidth+clog2(L) bits, signed); y_i = acc_i >>> shift (arithmetic,
//   floor); saturate y_i to signed resultBitwidth; registered to results at E1
//   (results = 2 edges after codes presented).
// - Slicer on registered results: d = results_i - thresh_i (resultBitwidth+1 signed).
//   bit_out_i = 1 iff d > 0 (equal -> 0). confidence_i = min(|d|, 2^confidenceBitwidth-1).
//   Registered at E2 (bit_out/confidence = 3 edges after codes).
// - Weights independent per channel; shift and threshold changes never corrupt history.
// - Reset mid-stream clears history: first post-reset word sees prev = 0.
// - Synthesizable; no $fopen/file I/O (recording done by bench-side logic_recorder).
// TESTING
// - Reset: stream random codes, pull rstb low mid-cycle -> results/bit_out/confidence 0
//   immediately; after release, first word's taps into prev see 0.
// - Identity: w[i][0]=256 else 0, shift=8, codes[i]=i-8 -> 2 edges later results[i]=i-8;
//   thresh=0 -> 3 edges later bit_out[i]=(i>8), confidence[i]=|i-8|.
// - Cross-word tap: w[i][1]=256 only, shift=8, word A then word B -> results for B:
//   [0]=A[15], [i]=B[i-1].
// - Saturation: all codes 127, all w=511, shift=0 -> results 127; codes -128 -> results -128.
// - Slicer limits: result 10/thresh 10 -> bit 0, conf 0; result 127/thresh -128 -> bit 1,
//   conf 255; result -128/thresh 127 -> bit 0, conf 255.
// - Shift rounding: identity taps with shift 8 -> 9: code -3 -> result -2; code 5 -> 2;
//   change visible exactly one edge later.

Source files
------------

// File: rtl/ffe_cmp_slice_if.sv
// Bus bundle for the FFE + slicer slice: control and data inputs toward the
// datapath, registered equaliser and slicer outputs back.
interface ffe_cmp_slice_if #(
  parameter int numChannels        = 16,
  parameter int maxWeightLength    = 10,
  parameter int codeBitwidth       = 8,
  parameter int weightBitwidth     = 10,
  parameter int resultBitwidth     = 8,
  parameter int shiftBitwidth      = 5,
  parameter int thresholdBitwidth  = 8,
  parameter int confidenceBitwidth = 8
);
  logic        [shiftBitwidth-1:0]      new_shift_index;
  logic signed [weightBitwidth-1:0]     new_weights [numChannels][maxWeightLength];
  logic signed [codeBitwidth-1:0]       codes       [numChannels];
  logic signed [thresholdBitwidth-1:0]  new_thresh  [numChannels];
  logic signed [resultBitwidth-1:0]     results     [numChannels];
  logic        [numChannels-1:0]        bit_out;
  logic        [confidenceBitwidth-1:0] confidence  [numChannels];

  modport master (
    output new_shift_index, new_weights, codes, new_thresh,
    input  results, bit_out, confidence
  );

  modport slave (
    input  new_shift_index, new_weights, codes, new_thresh,
    output results, bit_out, confidence
  );
endinterface

// File: rtl/ffe_cmp_slice.sv
// Parallel feed-forward equaliser followed by a per-channel threshold slicer.
// Pipeline: inputs/controls registered (E0), FFE result registered (E1),
// slicer bit and confidence registered (E2).
module ffe_cmp_slice #(
  parameter int numChannels        = 16,
  parameter int maxWeightLength    = 10,
  parameter int codeBitwidth       = 8,
  parameter int weightBitwidth     = 10,
  parameter int resultBitwidth     = 8,
  parameter int shiftBitwidth      = 5,
  parameter int thresholdBitwidth  = 8,
  parameter int confidenceBitwidth = 8
) (
  input  logic clk,
  input  logic rstb,
  ffe_cmp_slice_if.slave bus
);
  localparam int ACC_W  = codeBitwidth + weightBitwidth + $clog2(maxWeightLength);
  localparam int DIFF_W = resultBitwidth + 1;

  // Saturation bounds of the result word, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] RES_MAX_C =
    {{(ACC_W-resultBitwidth+1){1'b0}}, {(resultBitwidth-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN_C =
    {{(ACC_W-resultBitwidth+1){1'b1}}, {(resultBitwidth-1){1'b0}}};
  localparam logic [DIFF_W-1:0] CONF_MAX_C =
    {{(DIFF_W-confidenceBitwidth){1'b0}}, {confidenceBitwidth{1'b1}}};

  // Registered history and controls
  logic signed [codeBitwidth-1:0]      cur_r     [numChannels];
  logic signed [codeBitwidth-1:0]      prev_r    [numChannels];
  logic signed [weightBitwidth-1:0]    weights_r [numChannels][maxWeightLength];
  logic        [shiftBitwidth-1:0]     shift_r;
  logic signed [thresholdBitwidth-1:0] thresh_r  [numChannels];

  // Pipeline outputs
  logic signed [resultBitwidth-1:0]     results_r [numChannels];
  logic        [numChannels-1:0]        bit_r;
  logic        [confidenceBitwidth-1:0] conf_r    [numChannels];

  // Combinational datapath
  logic signed [codeBitwidth-1:0]       ext_s  [2*numChannels];
  logic signed [ACC_W-1:0]              acc_s  [numChannels];
  logic signed [ACC_W-1:0]              shr_s  [numChannels];
  logic signed [resultBitwidth-1:0]     ffe_s  [numChannels];
  logic signed [DIFF_W-1:0]             diff_s [numChannels];
  logic        [DIFF_W-1:0]             mag_s  [numChannels];
  logic        [numChannels-1:0]        bit_s;
  logic        [confidenceBitwidth-1:0] conf_s [numChannels];

  // Clamp a full-precision value into the signed result range.
  function automatic logic signed [resultBitwidth-1:0] sat_result(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [resultBitwidth-1:0] r;
    if (v > RES_MAX_C) begin
      r = RES_MAX_C[resultBitwidth-1:0];
    end else if (v < RES_MIN_C) begin
      r = RES_MIN_C[resultBitwidth-1:0];
    end else begin
      r = v[resultBitwidth-1:0];
    end
    return r;
  endfunction

  // Capture the incoming word, age the previous one, and latch the controls.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shift_r <= '0;
      for (int i = 0; i < numChannels; i++) begin
        cur_r[i]    <= '0;
        prev_r[i]   <= '0;
        thresh_r[i] <= '0;
        for (int k = 0; k < maxWeightLength; k++) begin
          weights_r[i][k] <= '0;
        end
      end
    end else begin
      shift_r <= bus.new_shift_index;
      for (int i = 0; i < numChannels; i++) begin
        cur_r[i]    <= bus.codes[i];
        prev_r[i]   <= cur_r[i];
        thresh_r[i] <= bus.new_thresh[i];
        for (int k = 0; k < maxWeightLength; k++) begin
          weights_r[i][k] <= bus.new_weights[i][k];
        end
      end
    end
  end

  // Two-word sample window: prev word first, then current word, in time order.
  always_comb begin
    for (int j = 0; j < 2*numChannels; j++) begin
      ext_s[j] = '0;
    end
    for (int j = 0; j < numChannels; j++) begin
      ext_s[j]             = prev_r[j];
      ext_s[numChannels+j] = cur_r[j];
    end
  end

  // FFE: full-precision multiply-accumulate, arithmetic shift, saturate.
  always_comb begin
    for (int i = 0; i < numChannels; i++) begin
      acc_s[i] = '0;
      for (int k = 0; k < maxWeightLength; k++) begin
        acc_s[i] = acc_s[i] + (ACC_W'(weights_r[i][k]) * ACC_W'(ext_s[numChannels+i-k]));
      end
      shr_s[i] = acc_s[i] >>> shift_r;
      ffe_s[i] = sat_result(shr_s[i]);
    end
  end

  // Register the equaliser outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < numChannels; i++) begin
        results_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < numChannels; i++) begin
        results_r[i] <= ffe_s[i];
      end
    end
  end

  // Slicer: signed difference, strict-positive decision, saturated magnitude.
  always_comb begin
    bit_s = '0;
    for (int i = 0; i < numChannels; i++) begin
      diff_s[i] = DIFF_W'(results_r[i]) - DIFF_W'(thresh_r[i]);
      bit_s[i]  = !diff_s[i][DIFF_W-1] && (diff_s[i] != '0);
      if (diff_s[i][DIFF_W-1]) begin
        mag_s[i] = -diff_s[i];
      end else begin
        mag_s[i] = diff_s[i];
      end
      if (mag_s[i] > CONF_MAX_C) begin
        conf_s[i] = CONF_MAX_C[confidenceBitwidth-1:0];
      end else begin
        conf_s[i] = mag_s[i][confidenceBitwidth-1:0];
      end
    end
  end

  // Register slicer decisions and confidence.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bit_r <= '0;
      for (int i = 0; i < numChannels; i++) begin
        conf_r[i] <= '0;
      end
    end else begin
      bit_r <= bit_s;
      for (int i = 0; i < numChannels; i++) begin
        conf_r[i] <= conf_s[i];
      end
    end
  end

  assign bus.results    = results_r;
  assign bus.bit_out    = bit_r;
  assign bus.confidence = conf_r;
endmodule

// File: tb/tb_ffe_cmp_slice.sv
// Directed self-checking bench for ffe_cmp_slice: vector table for single-tap
// arithmetic/slicer cases plus sequences for latency, cross-word taps,
// saturation, shift change and mid-stream reset.
module tb_ffe_cmp_slice;
  localparam int N  = 16;
  localparam int L  = 10;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ffe_cmp_slice_if #(.numChannels(N), .maxWeightLength(L)) bus ();

  ffe_cmp_slice #(.numChannels(N), .maxWeightLength(L)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0]  code;
    logic signed [9:0]  w0;
    logic        [4:0]  sh;
    logic signed [7:0]  th;
    logic signed [31:0] exp_res;
    logic signed [31:0] exp_bit;
    logic signed [31:0] exp_conf;
  } vec_t;

  vec_t vecs [9];
  logic signed [7:0] wa [N];
  logic signed [7:0] wb [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic set_ctl(input int tap, input logic signed [9:0] w,
                         input logic [4:0] sh, input logic signed [7:0] th);
    bus.new_shift_index = sh;
    for (int i = 0; i < N; i++) begin
      bus.new_thresh[i] = th;
      for (int k = 0; k < L; k++) begin
        bus.new_weights[i][k] = (k == tap || tap < 0) ? w : 10'sd0;
      end
    end
  endtask

  task automatic set_codes(input logic signed [7:0] c);
    for (int i = 0; i < N; i++) bus.codes[i] = c;
  endtask

  task automatic check_all_res(input string name, input logic signed [31:0] exp);
    for (int i = 0; i < N; i++) check(name, i, bus.results[i], exp);
  endtask

  task automatic check_zero_out(input string name);
    for (int i = 0; i < N; i++) begin
      check({name, "_res"}, i, bus.results[i], 0);
      check({name, "_bit"}, i, {31'd0, bus.bit_out[i]}, 0);
      check({name, "_conf"}, i, {24'd0, bus.confidence[i]}, 0);
    end
  endtask

  initial begin
    int e;
    vecs[0] = '{8'sd10,   10'sd256,  5'd8,  8'sd10,   10,   0, 0};
    vecs[1] = '{8'sd127,  10'sd511,  5'd0,  -8'sd128, 127,  1, 255};
    vecs[2] = '{-8'sd128, 10'sd511,  5'd0,  8'sd127,  -128, 0, 255};
    vecs[3] = '{-8'sd3,   10'sd256,  5'd9,  8'sd0,    -2,   0, 2};
    vecs[4] = '{8'sd5,    10'sd256,  5'd9,  8'sd0,    2,    1, 2};
    vecs[5] = '{8'sd100,  -10'sd256, 5'd8,  -8'sd50,  -100, 0, 50};
    vecs[6] = '{8'sd7,    10'sd3,    5'd1,  8'sd5,    10,   1, 5};
    vecs[7] = '{-8'sd1,   10'sd1,    5'd31, 8'sd0,    -1,   0, 1};
    vecs[8] = '{8'sd0,    10'sd256,  5'd8,  -8'sd1,   0,    1, 1};

    // Reset state
    set_ctl(0, 10'sd0, 5'd0, 8'sd0);
    set_codes(8'sd0);
    repeat (3) tick();
    check_zero_out("reset");
    @(negedge clk);
    rstb = 1'b1;

    // Identity with latency checks
    set_ctl(0, 10'sd256, 5'd8, 8'sd0);
    for (int i = 0; i < N; i++) bus.codes[i] = 8'(i - 8);
    tick();
    check_all_res("ident_lat1", 0);
    tick();
    for (int i = 0; i < N; i++) begin
      check("ident_res", i, bus.results[i], i - 8);
      check("ident_bit_lat2", i, {31'd0, bus.bit_out[i]}, 0);
    end
    tick();
    for (int i = 0; i < N; i++) begin
      check("ident_bit", i, {31'd0, bus.bit_out[i]}, (i > 8) ? 1 : 0);
      check("ident_conf", i, {24'd0, bus.confidence[i]}, (i >= 8) ? i - 8 : 8 - i);
    end

    // Cross-word tap: tap 1 only
    set_ctl(1, 10'sd256, 5'd8, 8'sd0);
    for (int i = 0; i < N; i++) begin
      wa[i] = 8'(3 * i - 20);
      wb[i] = 8'(50 - 5 * i);
    end
    bus.codes = wa;
    tick();
    bus.codes = wb;
    tick();
    set_codes(8'sd0);
    tick();
    check("xword_res", 0, bus.results[0], wa[N-1]);
    for (int i = 1; i < N; i++) check("xword_res", i, bus.results[i], wb[i-1]);

    // Table of single-tap vectors
    for (int v = 0; v < 9; v++) begin
      set_ctl(0, vecs[v].w0, vecs[v].sh, vecs[v].th);
      set_codes(vecs[v].code);
      tick();
      tick();
      for (int i = 0; i < N; i++) check($sformatf("vec%0d_res", v), i, bus.results[i], vecs[v].exp_res);
      tick();
      for (int i = 0; i < N; i++) begin
        check($sformatf("vec%0d_bit", v), i, {31'd0, bus.bit_out[i]}, vecs[v].exp_bit);
        check($sformatf("vec%0d_conf", v), i, {24'd0, bus.confidence[i]}, vecs[v].exp_conf);
      end
    end

    // Saturation with every tap at full weight
    set_ctl(-1, 10'sd511, 5'd0, 8'sd0);
    set_codes(8'sd127);
    repeat (3) tick();
    check_all_res("sat_pos", 127);
    set_codes(-8'sd128);
    repeat (3) tick();
    check_all_res("sat_neg", -128);

    // Shift change 8 -> 9 on steady code -3
    set_ctl(0, 10'sd256, 5'd8, 8'sd0);
    set_codes(-8'sd3);
    repeat (3) tick();
    check_all_res("shift8", -3);
    bus.new_shift_index = 5'd9;
    tick();
    check_all_res("shift_edge1", -3);
    tick();
    check_all_res("shift_edge2", -2);

    // Mid-stream reset: tap 9 reaches into prev for channels 0..8
    set_ctl(9, 10'sd256, 5'd8, 8'sd0);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) bus.codes[i] = 8'($urandom_range(1, 100));
      tick();
    end
    #3;
    rstb = 1'b0;
    #1;
    check_zero_out("midrst");
    for (int i = 0; i < N; i++) wa[i] = 8'($urandom_range(0, 255));
    bus.codes = wa;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    tick();
    for (int i = 0; i < N; i++) bus.codes[i] = 8'($urandom_range(0, 255));
    tick();
    for (int i = 0; i < N; i++) begin
      e = (i < 9) ? 0 : int'(wa[i-9]);
      check("postrst_res", i, bus.results[i], e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
